// File: rtl/mdu_issue_ctrl.sv
// Issue/hazard controller between the E stage and the multiply/divide unit.
// Drives MDU start/mt/op, shadows unit latency, stalls D and flags shadow/unit divergence.
module mdu_issue_ctrl #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10,
   parameter int unsigned CNT_W      = 4
) (
   input  logic        i_clk,
   input  logic        i_res,
   input  logic [3:0]  i_e_op,
   input  logic        i_e_flush,
   input  logic        i_d_uses_mdu,
   input  logic        i_mdu_busy,
   output logic        o_mdu_start,
   output logic        o_mdu_mt,
   output logic [2:0]  o_mdu_op,
   output logic        o_stall_d,
   output logic        o_done,
   output logic        o_sync_err,
   output logic [31:0] o_stall_cnt
);

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES);
   localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   state_e           r_state;
   state_e           w_state_d;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_d;
   logic             r_done;
   logic             w_done_d;
   logic             r_sync_err;
   logic             w_sync_err_d;
   logic [31:0]      r_stall_cnt;
   logic [31:0]      w_stall_cnt_d;

   logic             w_is_muldiv;
   logic             w_is_mul;
   logic             w_is_mt;
   logic             w_is_mf;
   logic [2:0]       w_op;
   logic             w_issue;
   logic             w_mt;
   logic             w_shadow_busy;
   logic             w_stall;

   always_comb begin
      w_is_muldiv = 1'b0;
      w_is_mul    = 1'b0;
      w_is_mt     = 1'b0;
      w_is_mf     = 1'b0;
      w_op        = 3'b000;
      case (i_e_op)
         4'd1: begin w_is_muldiv = 1'b1; w_is_mul = 1'b1; w_op = 3'b011; end
         4'd2: begin w_is_muldiv = 1'b1; w_is_mul = 1'b1; w_op = 3'b010; end
         4'd3: begin w_is_muldiv = 1'b1; w_op = 3'b101; end
         4'd4: begin w_is_muldiv = 1'b1; w_op = 3'b100; end
         4'd5, 4'd6: w_is_mf = 1'b1;
         4'd7: begin w_is_mt = 1'b1; w_op = 3'b001; end
         4'd8: begin w_is_mt = 1'b1; w_op = 3'b000; end
         default: ;
      endcase
   end

   // All combinational outputs are held low while reset is asserted.
   assign w_issue       = w_is_muldiv & ~i_e_flush & ~i_res;
   assign w_mt          = w_is_mt & ~i_e_flush & ~i_res;
   assign w_shadow_busy = (r_cnt != '0);
   assign w_stall       = ~i_res & i_d_uses_mdu & (w_issue | w_shadow_busy);

   assign o_mdu_start = w_issue;
   assign o_mdu_mt    = w_mt;
   assign o_mdu_op    = i_res ? 3'b000 : w_op;
   assign o_stall_d   = w_stall;
   assign o_done      = r_done;
   assign o_sync_err  = r_sync_err;
   assign o_stall_cnt = r_stall_cnt;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      if (w_issue) begin
         w_cnt_d   = w_is_mul ? MulLoad : DivLoad;
         w_state_d = w_is_mul ? StMul : StDiv;
      end else if (w_shadow_busy) begin
         w_cnt_d = r_cnt - CntOne;
         if (r_cnt == CntOne) begin
            w_state_d = StIdle;
         end
      end else begin
         w_state_d = StIdle;
      end
   end

   // A reload on the final busy cycle is a violation, not a completion.
   assign w_done_d = (r_state != StIdle) & (r_cnt == CntOne) & ~w_issue;

   assign w_sync_err_d = r_sync_err
                       | (w_shadow_busy != i_mdu_busy)
                       | (w_shadow_busy & (w_issue | w_mt | (w_is_mf & ~i_e_flush)));

   assign w_stall_cnt_d = (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) ?
                          r_stall_cnt + 32'd1 : r_stall_cnt;

   always_ff @(posedge i_clk or posedge i_res) begin
      if (i_res) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_sync_err  <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_done      <= w_done_d;
         r_sync_err  <= w_sync_err_d;
         r_stall_cnt <= w_stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: directed scenarios plus randomized legal traffic,
// checked against a cycle-count reference model of the shadow busy window.
module tb_mdu_issue_ctrl;

   logic        clk;
   logic        i_res;
   logic [3:0]  i_e_op;
   logic        i_e_flush;
   logic        i_d_uses_mdu;
   logic        i_mdu_busy;
   logic        o_mdu_start;
   logic        o_mdu_mt;
   logic [2:0]  o_mdu_op;
   logic        o_stall_d;
   logic        o_done;
   logic        o_sync_err;
   logic [31:0] o_stall_cnt;

   mdu_issue_ctrl dut (
      .i_clk        (clk),
      .i_res        (i_res),
      .i_e_op       (i_e_op),
      .i_e_flush    (i_e_flush),
      .i_d_uses_mdu (i_d_uses_mdu),
      .i_mdu_busy   (i_mdu_busy),
      .o_mdu_start  (o_mdu_start),
      .o_mdu_mt     (o_mdu_mt),
      .o_mdu_op     (o_mdu_op),
      .o_stall_d    (o_stall_d),
      .o_done       (o_done),
      .o_sync_err   (o_sync_err),
      .o_stall_cnt  (o_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        mt;
      logic [2:0]  op;
      logic        chk_op;
      logic        stall;
      logic        done;
      logic        err;
      logic [31:0] scnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: remaining busy cycles of the unit and the registered outputs.
   int     rem    = 0;
   bit     m_done = 0;
   bit     m_err  = 0;
   longint m_scnt = 0;

   function automatic logic [2:0] op_code(input int op);
      case (op)
         1: return 3'b011;
         2: return 3'b010;
         3: return 3'b101;
         4: return 3'b100;
         7: return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   // bmode: 0 = unit behaves ideally, 1 = busy forced low, 2 = busy forced high
   task automatic step(input int op, input bit fl, input bit d, input int bmode, input bit rst);
      exp_t e;
      bit   busy;
      bit   issue;
      bit   mtx;
      bit   mfx;
      @(posedge clk);
      #1;
      busy = (bmode == 0) ? (rem > 0) : (bmode == 2);
      i_e_op       = op[3:0];
      i_e_flush    = fl;
      i_d_uses_mdu = d;
      i_mdu_busy   = busy;
      i_res        = rst;
      if (rst) begin
         e = '{start: 0, mt: 0, op: 3'b000, chk_op: 1, stall: 0, done: 0, err: 0, scnt: 0};
         rem = 0; m_done = 0; m_err = 0; m_scnt = 0;
         q.push_back(e);
      end else begin
         issue = (op >= 1 && op <= 4) && !fl;
         mtx   = (op == 7 || op == 8) && !fl;
         mfx   = (op == 5 || op == 6) && !fl;
         e.start  = issue;
         e.mt     = mtx;
         e.op     = op_code(op);
         e.chk_op = issue || mtx;
         e.stall  = d && (issue || rem > 0);
         e.done   = m_done;
         e.err    = m_err;
         e.scnt   = m_scnt[31:0];
         q.push_back(e);
         if (((rem > 0) != busy) || (rem > 0 && (issue || mtx || mfx))) m_err = 1;
         m_done = (rem == 1) && !issue;
         if (issue) rem = (op <= 2) ? 5 : 10;
         else if (rem > 0) rem = rem - 1;
         if (e.stall && m_scnt < 64'h0000_0000_FFFF_FFFF) m_scnt = m_scnt + 1;
      end
   endtask

   task automatic idle(input int n, input bit d);
      for (int i = 0; i < n; i++) step(0, 0, d, 0, 0);
   endtask

   task automatic do_reset();
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("mdu_start", 32'(o_mdu_start), 32'(e.start));
         chk("mdu_mt", 32'(o_mdu_mt), 32'(e.mt));
         if (e.chk_op) chk("mdu_op", 32'(o_mdu_op), 32'(e.op));
         chk("stall_d", 32'(o_stall_d), 32'(e.stall));
         chk("done", 32'(o_done), 32'(e.done));
         chk("sync_err", 32'(o_sync_err), 32'(e.err));
         chk("stall_cnt", o_stall_cnt, e.scnt);
      end
   end

   initial begin
      i_res = 1'b1; i_e_op = '0; i_e_flush = 1'b0; i_d_uses_mdu = 1'b0; i_mdu_busy = 1'b0;
      do_reset();

      // mult with dependent D-stage MDU ops: 6 stall cycles, done after 5 busy cycles
      step(1, 0, 1, 0, 0);
      idle(5, 1);
      idle(3, 0);
      do_reset();

      // div then dependent ops: 11 stall cycles
      step(3, 0, 1, 0, 0);
      idle(10, 1);
      idle(3, 0);
      do_reset();

      // mtlo / mthi with idle unit
      step(8, 0, 1, 0, 0);
      step(7, 0, 1, 0, 0);
      idle(2, 1);

      // flushed multu and flushed mt
      step(2, 1, 1, 0, 0);
      step(8, 1, 1, 0, 0);
      idle(2, 1);

      // divu interrupted by reset three cycles in
      step(4, 0, 1, 0, 0);
      idle(3, 1);
      step(0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      idle(12, 1);

      // unit busy drops while shadow still counting
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      idle(10, 0);
      do_reset();

      // unit busy while shadow idle
      step(0, 0, 0, 2, 0);
      idle(3, 0);
      do_reset();

      // randomized legal traffic with occasional mid-operation resets
      for (int n = 0; n < 1500; n++) begin
         int op;
         bit fl;
         if ($urandom_range(0, 199) == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) step(0, 0, 0, 0, 1);
         end else begin
            if (rem > 0) begin
               int r;
               r  = $urandom_range(0, 3);
               fl = 1'b0;
               if (r == 0) op = 0;
               else if (r == 1) op = $urandom_range(9, 15);
               else begin op = $urandom_range(1, 8); fl = 1'b1; end
            end else begin
               op = $urandom_range(0, 15);
               fl = ($urandom_range(0, 7) == 0);
            end
            step(op, fl, 1'($urandom_range(0, 1)), 0, 0);
         end
      end
      do_reset();

      // protocol violations while busy: re-issue, mt, mf
      step(1, 0, 1, 0, 0);
      step(3, 0, 1, 0, 0);
      idle(12, 1);
      do_reset();
      step(3, 0, 0, 0, 0);
      step(8, 0, 0, 0, 0);
      idle(11, 0);
      do_reset();
      step(2, 0, 0, 0, 0);
      step(5, 0, 0, 0, 0);
      idle(6, 0);
      do_reset();
      idle(2, 0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
